// File: rtl/lzw_dict_lookup.sv
// LZW dictionary stage: linear-probed hash table of strings up to 8 bytes.
// A hit returns the stored code; a miss inserts the string under next_code.
module lzw_dict_lookup #(
  parameter int HASH_WIDTH = 11,
  parameter int CODE_WIDTH = 12,
  parameter int MAX_PROBE  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [63:0]           req_key,
  input  logic [2:0]            req_len,
  input  logic [HASH_WIDTH-1:0] req_hash,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [CODE_WIDTH-1:0] resp_code,
  output logic                  resp_full
);

  localparam int DEPTH = 1 << HASH_WIDTH;
  localparam int PW    = (MAX_PROBE > 1) ? $clog2(MAX_PROBE) : 1;
  localparam logic [PW-1:0]       LAST_PROBE = PW'(MAX_PROBE - 1);
  localparam logic [CODE_WIDTH:0] CODE_LIMIT = {1'b1, {CODE_WIDTH{1'b0}}};
  localparam logic [CODE_WIDTH:0] FIRST_CODE = (CODE_WIDTH + 1)'(256);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_COMPARE} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           probe_q, probe_d;
  logic [CODE_WIDTH:0]     next_code_q;
  logic [DEPTH-1:0]        valid_q;
  logic [63:0]             key_q;
  logic [2:0]              len_q;
  logic [HASH_WIDTH-1:0]   hash_q;
  logic [63:0]             rd_key_q;
  logic [2:0]              rd_len_q;
  logic [CODE_WIDTH-1:0]   rd_code_q;
  logic                    resp_valid_q, resp_hit_q, resp_full_q;
  logic [CODE_WIDTH-1:0]   resp_code_q;

  logic [63:0]             mem_key  [DEPTH];
  logic [2:0]              mem_len  [DEPTH];
  logic [CODE_WIDTH-1:0]   mem_code [DEPTH];

  logic                    accept, rd_en, do_write, resp_set;
  logic                    resp_hit_d, resp_full_d;
  logic [CODE_WIDTH-1:0]   resp_code_d;
  logic [HASH_WIDTH-1:0]   addr;
  logic                    slot_valid, key_match, have_code;

  // Only the low (len+1) bytes of a key are significant.
  function automatic logic [63:0] len_mask(input logic [2:0] len);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = (b <= int'(len)) ? 8'hFF : 8'h00;
    return m;
  endfunction

  assign addr       = hash_q + HASH_WIDTH'(probe_q);
  assign slot_valid = valid_q[addr];
  assign key_match  = slot_valid && (rd_len_q == len_q) &&
                      (((rd_key_q ^ key_q) & len_mask(len_q)) == 64'd0);
  assign have_code  = (next_code_q != CODE_LIMIT);
  assign req_ready  = (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    probe_d     = probe_q;
    accept      = 1'b0;
    rd_en       = 1'b0;
    do_write    = 1'b0;
    resp_set    = 1'b0;
    resp_hit_d  = 1'b0;
    resp_full_d = 1'b0;
    resp_code_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          probe_d = '0;
          if (req_len == 3'd0) begin
            resp_set    = 1'b1;
            resp_hit_d  = 1'b1;
            resp_code_d = CODE_WIDTH'(req_key[7:0]);
          end else begin
            state_d = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        rd_en   = 1'b1;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (key_match) begin
          resp_set    = 1'b1;
          resp_hit_d  = 1'b1;
          resp_code_d = rd_code_q;
          state_d     = S_IDLE;
        end else if (!slot_valid) begin
          resp_set = 1'b1;
          state_d  = S_IDLE;
          if (have_code) begin
            do_write    = 1'b1;
            resp_code_d = next_code_q[CODE_WIDTH-1:0];
          end else begin
            resp_full_d = 1'b1;
          end
        end else if (probe_q == LAST_PROBE) begin
          resp_set    = 1'b1;
          resp_full_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          probe_d = probe_q + PW'(1);
          state_d = S_LOOKUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A flush aborts whatever is in flight and refuses a same-cycle request.
    if (clear) begin
      state_d  = S_IDLE;
      probe_d  = '0;
      accept   = 1'b0;
      do_write = 1'b0;
      resp_set = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      probe_q      <= '0;
      next_code_q  <= FIRST_CODE;
      valid_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_full_q  <= 1'b0;
      resp_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      probe_q      <= probe_d;
      resp_valid_q <= resp_set;
      if (resp_set) begin
        resp_hit_q  <= resp_hit_d;
        resp_full_q <= resp_full_d;
        resp_code_q <= resp_code_d;
      end
      if (clear) begin
        next_code_q <= FIRST_CODE;
        valid_q     <= '0;
      end else if (do_write) begin
        next_code_q   <= next_code_q + (CODE_WIDTH + 1)'(1);
        valid_q[addr] <= 1'b1;
      end
    end
  end

  // Request capture and table storage carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      key_q  <= req_key;
      len_q  <= req_len;
      hash_q <= req_hash;
    end
    if (rd_en) begin
      rd_key_q  <= mem_key[addr];
      rd_len_q  <= mem_len[addr];
      rd_code_q <= mem_code[addr];
    end
    if (do_write) begin
      mem_key[addr]  <= key_q;
      mem_len[addr]  <= len_q;
      mem_code[addr] <= next_code_q[CODE_WIDTH-1:0];
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_code  = resp_code_q;
  assign resp_full  = resp_full_q;

endmodule

// File: doc/lzw_dict_lookup.md
# lzw_dict_lookup

LZW dictionary stage that sits directly downstream of the 64-bit LFSR string hasher. It accepts a candidate string (up to 8 bytes), its length code and its hash, and searches a linear-probed hash table. On a hit it returns the stored code; on a miss it inserts the string with the next free code. The result feeds the LZW control FSM, which either extends the current string or emits a code.

## Interface
- HASH_WIDTH, 11, table index width; table depth is 2^HASH_WIDTH
- CODE_WIDTH, 12, LZW code width; codes 0-255 are implicit single characters
- MAX_PROBE, 4, maximum table slots examined per request (1..2^HASH_WIDTH)

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  single-cycle pulse; flush dictionary
- req_valid  in  1  request strobe
- req_ready  out  1  block can accept a request
- req_key  in  64  string bytes; byte 0 = key[7:0]
- req_len  in  3  chars minus one (0 = 1 char, 7 = 8 chars)
- req_hash  in  HASH_WIDTH  hash index from the LFSR stage
- resp_valid  out  1  one-cycle result pulse
- resp_hit  out  1  1 = string found
- resp_code  out  CODE_WIDTH  found code, or newly assigned code on insert
- resp_full  out  1  miss could not be inserted (code space exhausted or probes exhausted)

## Operation
- Storage per slot: valid bit (flop array, clearable in one cycle), key[63:0], len[2:0], code (synchronous-read RAM, 1-cycle read latency).
- next_code register, reset/clear value 256.
- FSM states: IDLE, LOOKUP, COMPARE.
- IDLE: req_ready=1. On req_valid, latch key, len, hash; set probe=0.
  - req_len==0: no table access. Respond hit, code={0,key[7:0]}, and stay in IDLE.
  - Otherwise go to LOOKUP.
- LOOKUP: present read address (hash+probe) mod 2^HASH_WIDTH, then go to COMPARE.
- COMPARE, evaluated in priority order:
  - Slot valid, stored len==len, and stored key matches on the low 8*(len+1) bits (upper bytes are masked, not compared): respond hit with the stored code; go to IDLE.
  - Slot not valid, next_code < 2^CODE_WIDTH: write key, len, next_code; set the valid bit; respond miss with resp_code=next_code; increment next_code; go to IDLE.
  - Slot not valid, next_code == 2^CODE_WIDTH: respond miss, resp_full=1, resp_code=0, no write; go to IDLE.
  - Slot valid but mismatched, probe+1 < MAX_PROBE: increment probe; go to LOOKUP.
  - Slot valid but mismatched, probe+1 == MAX_PROBE: respond miss, resp_full=1, resp_code=0, no write; go to IDLE.
- next_code is CODE_WIDTH+1 bits wide and never exceeds 2^CODE_WIDTH.
- clear: in any state, on the next edge all valid bits go to 0, next_code goes to 256, and the FSM goes to IDLE. An in-flight request is aborted with no response. clear wins over a simultaneous req_valid, which is not accepted.
- Reset: state IDLE, all valid bits 0, next_code 256, probe 0.
  - Outputs during and after reset: resp_valid=0, resp_hit=0, resp_code=0, resp_full=0.
  - req_ready=1 while in IDLE, but requests are ignored while rst is high.
- Reset or clear asserted mid-operation never produces a partial write or a response.

## Timing
- Request accepted on an edge where req_valid && req_ready. Call it edge T.
- resp_* are registered outputs. resp_valid is high for exactly one cycle; there is no back-pressure.
- Single-char request: response visible in the cycle after edge T, i.e. latency 1. req_ready stays 1, so back-to-back single-char requests give 1 response per cycle.
- Multi-char request resolved on probe k (0-based): resp_valid visible after edge T+2(k+1).
  - Hit or insert on the first probe: latency 2. Worst case: latency 2*MAX_PROBE.
- req_ready is 0 in LOOKUP and COMPARE. It returns to 1 in the same cycle resp_valid is high, so a new request may be accepted on that edge.
- The insert write and the valid-bit set occur on the same edge that registers resp_valid. A lookup of the same string accepted at that edge hits.
- resp_hit, resp_code and resp_full hold their values until the next response.

## Test plan
- Reset, then key=0x41, len=0 -> 1 cycle later resp_valid=1, hit=1, code=0x041, full=0.
- Key=0x4241, len=1, hash=0x010 -> miss, code=256 at latency 2. Repeat the same request -> hit, code=256 at latency 2. Next new string gets code 257.
- Two distinct keys, same hash 0x7FF -> second inserts at slot 0x000 (wrap), code 257, latency 4. Re-query of the second key hits at latency 4.
- Fill MAX_PROBE=4 consecutive slots from hash 0x100, then a fifth colliding key -> miss, full=1, code=0, latency 8, next_code unchanged.
- Force next_code to 4096 via 3840 distinct inserts -> the next new string gets miss, full=1, no insert. clear -> the same string then inserts with code 256.
- Assert clear or rst in COMPARE of an inserting request -> no resp_valid, and a subsequent lookup of that key misses with code 256.
